// File: rtl/a2d_intf.sv
// SPI master for the ADC128S: a command frame, a gap, then a read frame, producing a 12-bit result.
// Optional frame check on the upper result nibble is enabled with `define A2D_FRM_CHK_EN.
module a2d_intf #(
    parameter int SCLK_DIV_BITS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic        err,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int N = SCLK_DIV_BITS;
    // sclk_cnt starts 8 below wrap so the first (non-shifting) SCLK fall lands 8 clks after SS_n falls
    localparam logic [N-1:0] PORCH = N'(2**N - 8);
    localparam logic [N-1:0] RISE  = N'(2**(N-1) - 1);
    localparam logic [N-1:0] FALL  = '1;

    typedef enum logic [1:0] {IDLE, TX1, GAP, TX2} state_t;

    state_t      state, state_nxt;
    logic [N-1:0] sclk_cnt, sclk_cnt_nxt;
    logic [4:0]  bit_cnt, bit_cnt_nxt;
    logic [15:0] shft, shft_nxt;
    logic [2:0]  ch, ch_nxt;
    logic        miso_smpl, miso_smpl_nxt;
    logic        ss_n_r, ss_n_nxt;
    logic        sclk_r, sclk_nxt;
    logic        cmplt_r, cmplt_nxt;
    logic [11:0] res_r, res_nxt;
    logic [15:0] word_in;

`ifdef A2D_FRM_CHK_EN
    logic        err_r, err_nxt;
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign word_in   = {shft[14:0], miso_smpl};
    assign SS_n      = ss_n_r;
    assign SCLK      = sclk_r;
    assign MOSI      = shft[15];
    assign cnv_cmplt = cmplt_r;
    assign res       = res_r;

    always_comb begin
        state_nxt     = state;
        sclk_cnt_nxt  = sclk_cnt;
        bit_cnt_nxt   = bit_cnt;
        shft_nxt      = shft;
        ch_nxt        = ch;
        miso_smpl_nxt = miso_smpl;
        ss_n_nxt      = ss_n_r;
        cmplt_nxt     = cmplt_r;
        res_nxt       = res_r;
`ifdef A2D_FRM_CHK_EN
        err_nxt       = err_r;
`endif
        case (state)
            IDLE: begin
                if (strt_cnv) begin
                    ch_nxt       = chnnl;
                    cmplt_nxt    = 1'b0;
`ifdef A2D_FRM_CHK_EN
                    err_nxt      = 1'b0;
`endif
                    shft_nxt     = {2'b00, chnnl, 11'h000};
                    sclk_cnt_nxt = PORCH;
                    bit_cnt_nxt  = 5'd0;
                    ss_n_nxt     = 1'b0;
                    state_nxt    = TX1;
                end
            end
            TX1, TX2: begin
                sclk_cnt_nxt = sclk_cnt + 1'b1;
                if (sclk_cnt == RISE) begin
                    miso_smpl_nxt = MISO;
                    bit_cnt_nxt   = bit_cnt + 5'd1;
                end
                // bit_cnt==0 here is the front-porch fall: nothing to shift yet
                if (sclk_cnt == FALL && bit_cnt != 5'd0) begin
                    shft_nxt = word_in;
                    if (bit_cnt == 5'd16) begin
                        ss_n_nxt = 1'b1;
                        if (state == TX1) begin
                            state_nxt = GAP;
                        end else begin
                            res_nxt   = word_in[11:0];
                            cmplt_nxt = 1'b1;
`ifdef A2D_FRM_CHK_EN
                            if (word_in[15:12] != 4'b0000) err_nxt = 1'b1;
`endif
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            GAP: begin
                // sclk_cnt wrapped to 0 at the end of TX1, so it doubles as the gap timer
                sclk_cnt_nxt = sclk_cnt + 1'b1;
                if (sclk_cnt == FALL) begin
                    shft_nxt     = {2'b00, ch, 11'h000};
                    sclk_cnt_nxt = PORCH;
                    bit_cnt_nxt  = 5'd0;
                    ss_n_nxt     = 1'b0;
                    state_nxt    = TX2;
                end
            end
            default: state_nxt = IDLE;
        endcase
        sclk_nxt = ss_n_nxt | sclk_cnt_nxt[N-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sclk_cnt  <= '0;
            bit_cnt   <= '0;
            shft      <= '0;
            ch        <= '0;
            miso_smpl <= 1'b0;
            ss_n_r    <= 1'b1;
            sclk_r    <= 1'b1;
            cmplt_r   <= 1'b0;
            res_r     <= '0;
`ifdef A2D_FRM_CHK_EN
            err_r     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            sclk_cnt  <= sclk_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shft      <= shft_nxt;
            ch        <= ch_nxt;
            miso_smpl <= miso_smpl_nxt;
            ss_n_r    <= ss_n_nxt;
            sclk_r    <= sclk_nxt;
            cmplt_r   <= cmplt_nxt;
            res_r     <= res_nxt;
`ifdef A2D_FRM_CHK_EN
            err_r     <= err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: behavioural ADC128S model, SPI pin monitor, table-driven channel sweep
// plus hand sequences for ignored starts, mid-frame reset and the frame check.
module tb_a2d_intf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        strt_cnv = 1'b0;
    logic [2:0]  chnnl = 3'd0;
    logic        cnv_cmplt, err, SS_n, SCLK, MOSI, MISO;
    logic [11:0] res;

    always #5 clk = ~clk;

    a2d_intf #(.SCLK_DIV_BITS(5)) dut (
        .clk(clk), .rst_n(rst_n), .strt_cnv(strt_cnv), .chnnl(chnnl),
        .cnv_cmplt(cnv_cmplt), .res(res), .err(err),
        .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
    );

`ifdef A2D_FRM_CHK_EN
    localparam logic EXP_FERR = 1'b1;
`else
    localparam logic EXP_FERR = 1'b0;
`endif

    // ADC model: channel latched from the previous frame's command, data MSB first,
    // advancing on every SCLK fall except the front-porch one.
    logic [11:0] analog_mem [8];
    logic        force_en = 1'b0;
    logic [15:0] force_word = 16'hF123;
    logic [15:0] adc_word = 16'h0000;
    logic [15:0] cmd_sr = 16'h0000;
    logic [2:0]  cur_ch = 3'd0;
    logic        ss_prev = 1'b1;
    int          idx = 0;
    int          nfall = 0;

    always @(negedge SCLK or negedge SS_n or posedge SS_n) begin
        if (SS_n === 1'b0 && ss_prev) begin
            idx = 0;
            nfall = 0;
            adc_word = force_en ? force_word : {4'h0, analog_mem[cur_ch]};
        end else if (SS_n === 1'b0) begin
            if (nfall > 0) idx++;
            nfall++;
        end else if (SS_n === 1'b1 && !ss_prev) begin
            cur_ch = cmd_sr[13:11];
        end
        ss_prev = (SS_n !== 1'b0);
    end

    always @(posedge SCLK) if (SS_n === 1'b0) cmd_sr = {cmd_sr[14:0], MOSI};

    assign MISO = (SS_n === 1'b0 && idx < 16) ? adc_word[4'(15 - idx)] : 1'b0;

    // Pin monitor, sampled mid-cycle
    typedef struct { int win; int rises; int porch; int gap; logic [15:0] mosi; } frm_t;
    frm_t        frm_q[$];
    int          m_win = 0, m_rises = 0, m_porch = -1, m_gap = 0, m_hi = 0;
    logic [15:0] m_mosi = 16'h0;
    logic        m_prev_ss = 1'b1, m_prev_sclk = 1'b1, m_prev_mosi = 1'b0;
    int          sclk_viol = 0, mosi_viol = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (SS_n && !SCLK) sclk_viol++;
            if (!SS_n) begin
                if (m_prev_ss) begin
                    m_gap = m_hi; m_win = 1; m_rises = 0; m_porch = -1; m_mosi = 16'h0;
                end else begin
                    m_win++;
                    if (!m_prev_sclk && SCLK) begin
                        m_rises++;
                        m_mosi = {m_mosi[14:0], MOSI};
                    end
                    if (MOSI !== m_prev_mosi && !(m_prev_sclk && !SCLK)) mosi_viol++;
                end
                if (!SCLK && m_porch < 0) m_porch = m_win - 1;
                m_hi = 0;
            end else begin
                if (!m_prev_ss) frm_q.push_back('{m_win, m_rises, m_porch, m_gap, m_mosi});
                m_hi++;
            end
        end
        m_prev_ss = SS_n; m_prev_sclk = SCLK; m_prev_mosi = MOSI;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where cnv_cmplt is first seen high.
    // lat counts clk edges from the accepting edge (1) to the completing edge.
    task automatic run_conv(input logic [2:0] ch, input int ign1, input int ign2, output int lat);
        int n;
        strt_cnv = 1'b1;
        chnnl = ch;
        @(negedge clk);
        strt_cnv = 1'b0;
        n = 1;
        chk("cmplt_drop", cnv_cmplt, 1'b0);
        while (!cnv_cmplt && n < 3000) begin
            if (n == ign1 || n == ign2) begin
                strt_cnv = 1'b1;
                chnnl = 3'd5;
            end else begin
                strt_cnv = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        strt_cnv = 1'b0;
        lat = n;
    endtask

    typedef struct { logic [2:0] ch; logic [11:0] exp_res; } vec_t;
    vec_t tbl[8];

    initial begin
        int lat;
        analog_mem[0] = 12'h001; analog_mem[1] = 12'h5A5;
        analog_mem[2] = 12'h2C2; analog_mem[3] = 12'hABC;
        analog_mem[4] = 12'hFFF; analog_mem[5] = 12'h555;
        analog_mem[6] = 12'h800; analog_mem[7] = 12'h7FE;
        tbl[0] = '{3'd0, 12'h001}; tbl[1] = '{3'd1, 12'h5A5};
        tbl[2] = '{3'd2, 12'h2C2}; tbl[3] = '{3'd3, 12'hABC};
        tbl[4] = '{3'd4, 12'hFFF}; tbl[5] = '{3'd5, 12'h555};
        tbl[6] = '{3'd6, 12'h800}; tbl[7] = '{3'd7, 12'h7FE};

        repeat (3) @(negedge clk);
        chk("rst_ss_n", SS_n, 1'b1);
        chk("rst_sclk", SCLK, 1'b1);
        chk("rst_mosi", MOSI, 1'b0);
        chk("rst_cmplt", cnv_cmplt, 1'b0);
        chk("rst_res", res, 12'h000);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic conversion on channel 3 with full frame timing
        frm_q.delete();
        run_conv(3'd3, -1, -1, lat);
        chk("ch3_latency", lat, 1073);
        chk("ch3_res", res, 12'hABC);
        chk("ch3_err", err, 1'b0);
        @(negedge clk);
        chk("ch3_cmplt_hold", cnv_cmplt, 1'b1);
        chk("ch3_frames", frm_q.size(), 2);
        if (frm_q.size() == 2) begin
            chk("f1_win", frm_q[0].win, 520);
            chk("f1_rises", frm_q[0].rises, 16);
            chk("f1_porch", frm_q[0].porch, 8);
            chk("f1_mosi", frm_q[0].mosi, 16'h1800);
            chk("gap_len", frm_q[1].gap, 32);
            chk("f2_win", frm_q[1].win, 520);
            chk("f2_rises", frm_q[1].rises, 16);
            chk("f2_porch", frm_q[1].porch, 8);
            chk("f2_mosi", frm_q[1].mosi, 16'h1800);
        end

        // Back-to-back channel sweep
        for (int i = 0; i < 8; i++) begin
            run_conv(tbl[i].ch, -1, -1, lat);
            chk($sformatf("sweep%0d_res", i), res, tbl[i].exp_res);
            chk($sformatf("sweep%0d_lat", i), lat, 1073);
        end

        // Starts during a conversion are ignored
        @(negedge clk);
        frm_q.delete();
        run_conv(3'd2, 100, 600, lat);
        chk("ign_latency", lat, 1073);
        chk("ign_res", res, 12'h2C2);
        @(negedge clk);
        chk("ign_frames", frm_q.size(), 2);
        if (frm_q.size() == 2) chk("ign_f2_mosi", frm_q[1].mosi, 16'h1000);

        // Reset in the middle of TX1
        strt_cnv = 1'b1;
        chnnl = 3'd6;
        @(negedge clk);
        strt_cnv = 1'b0;
        repeat (299) @(negedge clk);
        chk("pre_rst_ss_low", SS_n, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ss_n", SS_n, 1'b1);
        chk("midrst_sclk", SCLK, 1'b1);
        chk("midrst_cmplt", cnv_cmplt, 1'b0);
        chk("midrst_res", res, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_conv(3'd1, -1, -1, lat);
        chk("postrst_res", res, 12'h5A5);
        chk("postrst_lat", lat, 1073);

        // Non-zero upper nibble in the returned word
        force_en = 1'b1;
        run_conv(3'd4, -1, -1, lat);
        chk("frm_res", res, 12'h123);
        chk("frm_err", err, EXP_FERR);
        force_en = 1'b0;
        run_conv(3'd7, -1, -1, lat);
        chk("clean_res", res, 12'h7FE);
        chk("clean_err", err, 1'b0);

        @(negedge clk);
        chk("sclk_high_when_idle", sclk_viol, 0);
        chk("mosi_only_at_fall", mosi_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
